wb_result_stage: RTL and testbench

Parametrised, pipelined write-back result stage for the RISC-V core. It selects one of `NSRC` result sources, then aligns and sign/zero-extends load data. The selected result is registered into a two-entry skid buffer with a valid/ready handshake towards the register-file write port. It supersedes the single-cycle 3:1 result mux for the pipelined core: it adds an immediate source for LUI, load formatting, error flagging and back-pressure.

---
 rtl/wb_pkg.sv | 27 ++
 rtl/wb_load_ext.sv | 56 +++++
 rtl/wb_result_stage.sv | 173 +++++++++++++++++
 tb/tb_wb_result_stage.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared constants for the write-back result stage: source indices,
// load funct3 encodings, error bit positions and skid-buffer states.
package wb_pkg;

  localparam int SRC_ALU = 0;
  localparam int SRC_MEM = 1;
  localparam int SRC_PC4 = 2;
  localparam int SRC_IMM = 3;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam int ERR_ILL = 0;
  localparam int ERR_MIS = 1;

  typedef enum logic [1:0] {
    SK_EMPTY = 2'd0,
    SK_MAIN  = 2'd1,
    SK_FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/wb_load_ext.sv
// Load formatter: picks the byte/half/word/double at addr_lo out of the
// read data and extends it; flags illegal funct3 and misaligned accesses.
module wb_load_ext
  import wb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] data,
  input  logic [2:0]       funct3,
  input  logic [2:0]       addr_lo,
  output logic [WIDTH-1:0] value,
  output logic             illegal,
  output logic             misaligned
);

  logic [2:0]       off;
  logic [WIDTH-1:0] sh;

  // a 32-bit datapath has only four byte lanes, so addr_lo[2] is ignored
  assign off = (WIDTH == 64) ? addr_lo : {1'b0, addr_lo[1:0]};
  assign sh  = data >> {off, 3'b000};

  always_comb begin
    value      = '0;
    illegal    = 1'b0;
    misaligned = 1'b0;
    case (funct3)
      F3_LB:  value = WIDTH'(signed'(sh[7:0]));
      F3_LBU: value = WIDTH'(sh[7:0]);
      F3_LH:  value = WIDTH'(signed'(sh[15:0]));
      F3_LHU: value = WIDTH'(sh[15:0]);
      F3_LW: begin
        misaligned = (off[1:0] != 2'b00);
        value      = WIDTH'(signed'(sh[31:0]));
      end
      F3_LWU: begin
        if (WIDTH == 64) begin
          misaligned = (off[1:0] != 2'b00);
          value      = WIDTH'(sh[31:0]);
        end else begin
          illegal = 1'b1;
        end
      end
      F3_LD: begin
        if (WIDTH == 64) begin
          misaligned = (off != 3'b000);
          value      = sh;
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_result_stage.sv
// Write-back result stage: source select, load formatting and error
// qualification, followed by a two-entry skid buffer towards the register file.
//
// state    | meaning
// SK_EMPTY | main and skid empty
// SK_MAIN  | main holds an item, skid empty
// SK_FULL  | main and skid both hold items, in_ready low
module wb_result_stage
  import wb_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int NSRC  = 4,
  localparam int SEL_W = $clog2(NSRC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      ResultSrc,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic [2:0]            ld_funct3,
  input  logic [2:0]            ld_addr_lo,
  input  logic [4:0]            rd_in,
  input  logic                  RegWrite_in,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      Result,
  output logic [4:0]            rd_out,
  output logic                  RegWrite_out,
  output logic [1:0]            err
);

  logic [WIDTH-1:0] sel_val;
  logic [WIDTH-1:0] mem_data;
  logic [WIDTH-1:0] ld_val;
  logic [WIDTH-1:0] res_new;
  logic             sel_ok;
  logic             is_mem;
  logic             ld_ill;
  logic             ld_mis;
  logic [1:0]       err_new;
  logic             we_new;

  always_comb begin
    sel_val = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (ResultSrc == SEL_W'(k)) sel_val = src_data[k*WIDTH +: WIDTH];
    end
  end

  generate
    if (NSRC == (1 << SEL_W)) begin : g_sel_full
      assign sel_ok = 1'b1;
    end else begin : g_sel_part
      assign sel_ok = (ResultSrc < SEL_W'(NSRC));
    end
  endgenerate

  assign mem_data = src_data[SRC_MEM*WIDTH +: WIDTH];
  assign is_mem   = (ResultSrc == SEL_W'(SRC_MEM));

  wb_load_ext #(.WIDTH(WIDTH)) u_load_ext (
    .data       (mem_data),
    .funct3     (ld_funct3),
    .addr_lo    (ld_addr_lo),
    .value      (ld_val),
    .illegal    (ld_ill),
    .misaligned (ld_mis)
  );

  always_comb begin
    err_new          = '0;
    err_new[ERR_ILL] = !sel_ok || (is_mem && ld_ill);
    err_new[ERR_MIS] = sel_ok && is_mem && !ld_ill && ld_mis;
  end

  assign res_new = (|err_new) ? '0 : (is_mem ? ld_val : sel_val);
  assign we_new  = RegWrite_in && !(|err_new);

  skid_state_t      state, state_nx;
  logic             main_valid, skid_valid;
  logic             accept, drain;
  logic             ld_main_new, ld_main_skid, ld_skid;
  logic [WIDTH-1:0] main_res, skid_res;
  logic [4:0]       main_rd, skid_rd;
  logic             main_we, skid_we;
  logic [1:0]       main_err, skid_err;

  assign main_valid = (state != SK_EMPTY);
  assign skid_valid = (state == SK_FULL);
  assign in_ready   = !skid_valid;
  assign accept     = in_valid && in_ready && !flush;
  assign drain      = main_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SK_EMPTY;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    ld_main_new  = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    if (flush) begin
      state_nx = SK_EMPTY;
    end else begin
      case (state)
        SK_EMPTY: begin
          if (accept) begin
            ld_main_new = 1'b1;
            state_nx    = SK_MAIN;
          end
        end
        SK_MAIN: begin
          if (drain) begin
            if (accept) ld_main_new = 1'b1;
            else        state_nx    = SK_EMPTY;
          end else if (accept) begin
            ld_skid  = 1'b1;
            state_nx = SK_FULL;
          end
        end
        SK_FULL: begin
          if (drain) begin
            ld_main_skid = 1'b1;
            state_nx     = SK_MAIN;
          end
        end
        default: state_nx = SK_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_res <= '0;
      main_rd  <= '0;
      main_we  <= 1'b0;
      main_err <= '0;
      skid_res <= '0;
      skid_rd  <= '0;
      skid_we  <= 1'b0;
      skid_err <= '0;
    end else begin
      if (ld_main_new) begin
        main_res <= res_new;
        main_rd  <= rd_in;
        main_we  <= we_new;
        main_err <= err_new;
      end else if (ld_main_skid) begin
        main_res <= skid_res;
        main_rd  <= skid_rd;
        main_we  <= skid_we;
        main_err <= skid_err;
      end
      if (ld_skid) begin
        skid_res <= res_new;
        skid_rd  <= rd_in;
        skid_we  <= we_new;
        skid_err <= err_new;
      end
    end
  end

  assign out_valid    = main_valid;
  assign Result       = main_res;
  assign rd_out       = main_rd;
  assign RegWrite_out = main_we;
  assign err          = main_err;

endmodule

// File: tb/tb_wb_result_stage.sv
// Bench for wb_result_stage: three instances (32b/4 sources, 32b/3 sources,
// 64b/4 sources) driven in lockstep against a queue-based reference model.
module tb_wb_result_stage;

  typedef struct packed {
    logic [63:0] res;
    logic [4:0]  rd;
    logic        we;
    logic [1:0]  err;
  } item_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic        flush;
  logic [1:0]  ResultSrc;
  logic [2:0]  ld_funct3;
  logic [2:0]  ld_addr_lo;
  logic [4:0]  rd_in;
  logic        RegWrite_in;
  logic [63:0] vals [4];

  logic [127:0] src_a;
  logic [95:0]  src_b;
  logic [255:0] src_c;

  assign src_a = {vals[3][31:0], vals[2][31:0], vals[1][31:0], vals[0][31:0]};
  assign src_b = {vals[2][31:0], vals[1][31:0], vals[0][31:0]};
  assign src_c = {vals[3], vals[2], vals[1], vals[0]};

  logic        ov_a, ir_a, we_a, ov_b, ir_b, we_b, ov_c, ir_c, we_c;
  logic [31:0] res_a, res_b;
  logic [63:0] res_c;
  logic [4:0]  rd_a, rd_b, rd_c;
  logic [1:0]  err_a, err_b, err_c;

  wb_result_stage #(.WIDTH(32), .NSRC(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_a),
    .ResultSrc(ResultSrc), .src_data(src_a), .ld_funct3(ld_funct3),
    .ld_addr_lo(ld_addr_lo), .rd_in(rd_in), .RegWrite_in(RegWrite_in),
    .flush(flush), .out_valid(ov_a), .out_ready(out_ready), .Result(res_a),
    .rd_out(rd_a), .RegWrite_out(we_a), .err(err_a));

  wb_result_stage #(.WIDTH(32), .NSRC(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_b),
    .ResultSrc(ResultSrc), .src_data(src_b), .ld_funct3(ld_funct3),
    .ld_addr_lo(ld_addr_lo), .rd_in(rd_in), .RegWrite_in(RegWrite_in),
    .flush(flush), .out_valid(ov_b), .out_ready(out_ready), .Result(res_b),
    .rd_out(rd_b), .RegWrite_out(we_b), .err(err_b));

  wb_result_stage #(.WIDTH(64), .NSRC(4)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_c),
    .ResultSrc(ResultSrc), .src_data(src_c), .ld_funct3(ld_funct3),
    .ld_addr_lo(ld_addr_lo), .rd_in(rd_in), .RegWrite_in(RegWrite_in),
    .flush(flush), .out_valid(ov_c), .out_ready(out_ready), .Result(res_c),
    .rd_out(rd_c), .RegWrite_out(we_c), .err(err_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    checks   = 0;
  int    failures = 0;
  item_t q_a[$], q_b[$], q_c[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sx(input logic [63:0] x, input int n);
    logic [63:0] m;
    m = (64'd1 << n) - 64'd1;
    return x[n-1] ? (x | ~m) : (x & m);
  endfunction

  // Expected item for the current inputs, computed from the load rules on
  // a byte-shifted copy of the read data.
  function automatic item_t ref_item(input int w, input int nsrc);
    item_t       it;
    logic [63:0] mask, d, word, v;
    int          off;
    logic        ill, mis;
    mask = (w == 64) ? {64{1'b1}} : 64'h0000_0000_FFFF_FFFF;
    ill = 1'b0;
    mis = 1'b0;
    v   = '0;
    if (int'(ResultSrc) >= nsrc) begin
      ill = 1'b1;
    end else if (ResultSrc != 2'd1) begin
      v = vals[ResultSrc];
    end else begin
      d    = vals[1] & mask;
      off  = (w == 64) ? int'(ld_addr_lo) : int'(ld_addr_lo) % 4;
      word = d >> (8 * off);
      case (ld_funct3)
        3'd0: v = sx(word, 8);
        3'd4: v = word & 64'hFF;
        3'd1: v = sx(word, 16);
        3'd5: v = word & 64'hFFFF;
        3'd2: begin mis = (off % 4) != 0; v = sx(word, 32); end
        3'd6: if (w == 32) ill = 1'b1;
              else begin mis = (off % 4) != 0; v = word & 64'hFFFF_FFFF; end
        3'd3: if (w == 32) ill = 1'b1;
              else begin mis = (off != 0); v = word; end
        default: ill = 1'b1;
      endcase
    end
    if (ill || mis) v = '0;
    it.res = v & mask;
    it.rd  = rd_in;
    it.err = {mis, ill};
    it.we  = RegWrite_in && !(ill || mis);
    return it;
  endfunction

  task automatic chk_dut(input string p, input int n, input item_t h,
                         input logic ov, input logic ir, input logic [63:0] res,
                         input logic [4:0] rd, input logic we, input logic [1:0] err);
    chk({p, ".out_valid"}, 64'(ov), 64'(n > 0));
    chk({p, ".in_ready"}, 64'(ir), 64'(n < 2));
    if (n > 0) begin
      chk({p, ".Result"}, res, h.res);
      chk({p, ".rd_out"}, 64'(rd), 64'(h.rd));
      chk({p, ".RegWrite_out"}, 64'(we), 64'(h.we));
      chk({p, ".err"}, 64'(err), 64'(h.err));
    end
  endtask

  task automatic chk_rst(input string p, input logic ov, input logic ir, input logic [63:0] res,
                         input logic [4:0] rd, input logic we, input logic [1:0] err);
    chk({p, ".rst_out_valid"}, 64'(ov), 64'd0);
    chk({p, ".rst_in_ready"}, 64'(ir), 64'd1);
    chk({p, ".rst_Result"}, res, 64'd0);
    chk({p, ".rst_rd_out"}, 64'(rd), 64'd0);
    chk({p, ".rst_RegWrite_out"}, 64'(we), 64'd0);
    chk({p, ".rst_err"}, 64'(err), 64'd0);
  endtask

  task automatic chk_reset_all();
    chk_rst("A", ov_a, ir_a, 64'(res_a), rd_a, we_a, err_a);
    chk_rst("B", ov_b, ir_b, 64'(res_b), rd_b, we_b, err_b);
    chk_rst("C", ov_c, ir_c, res_c, rd_c, we_c, err_c);
  endtask

  // Compare outputs with the model head, then advance the model across one edge.
  task automatic do_cycle();
    int    n;
    logic  acc, drn;
    item_t ha, hb, hc;
    n  = q_a.size();
    ha = (n > 0) ? q_a[0] : '0;
    hb = (n > 0) ? q_b[0] : '0;
    hc = (n > 0) ? q_c[0] : '0;
    chk_dut("A", n, ha, ov_a, ir_a, 64'(res_a), rd_a, we_a, err_a);
    chk_dut("B", n, hb, ov_b, ir_b, 64'(res_b), rd_b, we_b, err_b);
    chk_dut("C", n, hc, ov_c, ir_c, res_c, rd_c, we_c, err_c);
    acc = in_valid && (n < 2) && !flush;
    drn = out_ready && (n > 0);
    if (flush) begin
      q_a.delete(); q_b.delete(); q_c.delete();
    end else begin
      if (drn) begin
        void'(q_a.pop_front()); void'(q_b.pop_front()); void'(q_c.pop_front());
      end
      if (acc) begin
        q_a.push_back(ref_item(32, 4));
        q_b.push_back(ref_item(32, 3));
        q_c.push_back(ref_item(64, 4));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_item(input logic [1:0] sel, input logic [2:0] f3, input logic [2:0] a);
    ResultSrc   = sel;
    ld_funct3   = f3;
    ld_addr_lo  = a;
    rd_in       = 5'($urandom);
    RegWrite_in = 1'b1;
    vals[0]     = {$urandom, $urandom};
    vals[2]     = {$urandom, $urandom};
    vals[3]     = {$urandom, $urandom};
  endtask

  task automatic push1(input logic [1:0] sel, input logic [2:0] f3, input logic [2:0] a);
    set_item(sel, f3, a);
    in_valid = 1'b1;
    do_cycle();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    ResultSrc = '0; ld_funct3 = '0; ld_addr_lo = '0; rd_in = '0; RegWrite_in = 1'b0;
    for (int i = 0; i < 4; i++) vals[i] = {$urandom, $urandom};
    @(negedge clk);
    @(negedge clk);
    chk_reset_all();
    rst_n = 1'b1;
    @(negedge clk);

    // back-to-back stream of non-load sources
    in_valid = 1'b1;
    set_item(2'd0, 3'd0, 3'd0); do_cycle();
    set_item(2'd2, 3'd0, 3'd0); do_cycle();
    set_item(2'd3, 3'd0, 3'd0); RegWrite_in = 1'b0; do_cycle();
    in_valid = 1'b0;
    do_cycle();
    do_cycle();

    // directed load formatting
    vals[1] = 64'h1234_5678_8000_F0A5;
    push1(2'd1, 3'b000, 3'd0);
    chk("lb_a0", 64'(res_a), 64'hFFFF_FFA5);
    chk("lb_c0", res_c, 64'hFFFF_FFFF_FFFF_FFA5);
    push1(2'd1, 3'b100, 3'd3);
    chk("lbu_a3", 64'(res_a), 64'h80);
    push1(2'd1, 3'b101, 3'd2);
    chk("lhu_a2", 64'(res_a), 64'h8000);
    push1(2'd1, 3'b001, 3'd2);
    chk("lh_a2", 64'(res_a), 64'hFFFF_8000);
    push1(2'd1, 3'b010, 3'd2);
    chk("lw_mis_res", 64'(res_a), 64'd0);
    chk("lw_mis_err", 64'(err_a), 64'd2);
    chk("lw_mis_we", 64'(we_a), 64'd0);
    push1(2'd1, 3'b010, 3'd4);
    chk("lw_a4_ignored", 64'(res_a), 64'h8000_F0A5);
    push1(2'd3, 3'b000, 3'd0);
    chk("sel3_b_res", 64'(res_b), 64'd0);
    chk("sel3_b_err", 64'(err_b), 64'd1);
    push1(2'd1, 3'b011, 3'd0);
    chk("ld_c0", res_c, 64'h1234_5678_8000_F0A5);
    chk("ld_a_err", 64'(err_a), 64'd1);
    push1(2'd1, 3'b011, 3'd4);
    chk("ld_c4_err", 64'(err_c), 64'd2);
    push1(2'd1, 3'b110, 3'd4);
    chk("lwu_c4", res_c, 64'h1234_5678);
    push1(2'd1, 3'b111, 3'd0);
    chk("f3_7_err", 64'(err_a), 64'd1);
    do_cycle();

    // back-pressure: A held, B in skid, C stalled, then release
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_item(2'd0, 3'd0, 3'd0); do_cycle();
    set_item(2'd2, 3'd0, 3'd0); do_cycle();
    set_item(2'd3, 3'd0, 3'd0); do_cycle();
    chk("full_in_ready", 64'(ir_a), 64'd0);
    do_cycle();
    out_ready = 1'b1;
    do_cycle();
    do_cycle();
    in_valid = 1'b0;
    do_cycle();
    do_cycle();

    // flush with both entries full and a pending item, then with skid free
    out_ready = 1'b0;
    push1(2'd0, 3'd0, 3'd0);
    push1(2'd2, 3'd0, 3'd0);
    set_item(2'd3, 3'd0, 3'd0);
    in_valid = 1'b1;
    flush    = 1'b1;
    do_cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", 64'(ov_a), 64'd0);
    chk("flush_in_ready", 64'(ir_a), 64'd1);
    push1(2'd0, 3'd0, 3'd0);
    set_item(2'd2, 3'd0, 3'd0);
    in_valid = 1'b1;
    flush    = 1'b1;
    do_cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    do_cycle();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 2) != 0);
      flush       = ($urandom_range(0, 19) == 0);
      ResultSrc   = 2'($urandom_range(0, 3));
      ld_funct3   = 3'($urandom);
      ld_addr_lo  = 3'($urandom);
      rd_in       = 5'($urandom);
      RegWrite_in = 1'($urandom);
      for (int k = 0; k < 4; k++) vals[k] = {$urandom, $urandom};
      do_cycle();
    end
    flush = 1'b0;

    // reset asserted with two items held
    out_ready = 1'b0;
    push1(2'd0, 3'd0, 3'd0);
    push1(2'd2, 3'd0, 3'd0);
    in_valid = 1'b1;
    rst_n    = 1'b0;
    #1;
    chk_reset_all();
    q_a.delete(); q_b.delete(); q_c.delete();
    @(posedge clk);
    @(negedge clk);
    chk_reset_all();
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    do_cycle();
    push1(2'd1, 3'b011, 3'd0);
    do_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
